// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// state encoding, opcode/funct constants, datapath mux encodings,
// the control-vector struct and the DECODE dispatch helper.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_I_EXEC   = 4'd9,
        ST_I_WB     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_JAL      = 4'd13,
        ST_JR       = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b011;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_A      = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] MEM2REG_ALUOUT = 2'd0;
    localparam logic [1:0] MEM2REG_MDR    = 2'd1;
    localparam logic [1:0] MEM2REG_PC     = 2'd2;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_A  = 1'b1;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_SEXT    = 2'd2;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '{default: '0};

    // State that follows DECODE for a given instruction; ST_FETCH means
    // the opcode is unsupported (retired as a nop).
    function automatic state_t dispatch(input logic [5:0] opcode, input logic [5:0] funct);
        state_t nxt;
        case (opcode)
            OP_RTYPE: nxt = (funct == FUNCT_JR) ? ST_JR : ST_R_EXEC;
            OP_LW,
            OP_SW:    nxt = ST_MEM_ADDR;
            OP_BEQ,
            OP_BNE:   nxt = ST_BRANCH;
            OP_ADDI,
            OP_SLTI:  nxt = ST_I_EXEC;
            OP_J:     nxt = ST_JUMP;
            OP_JAL:   nxt = ST_JAL;
            default:  nxt = ST_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-vector table for the multi-cycle sequencer.
// Ports:
//   i_state     current state register
//   i_mem_ready memory handshake (only qualifies the PC/IR load in FETCH)
//   i_slt       registered "instruction is slti" flag (selects I_EXEC ALU op)
//   i_bne       registered "instruction is bne" flag (branch sense)
//   o_ctrl      full control vector
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    input  logic   i_slt,
    input  logic   i_bne,
    output ctrl_t  o_ctrl
);

    // Per-state control table; every field defaults to zero.
    always_comb begin
        o_ctrl = CTRL_ZERO;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.iord      = 1'b0;
                o_ctrl.mem_read  = 1'b1;
                // PC and IR load only on the cycle the fetch completes.
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut.
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_SEXT_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                o_ctrl.alu_src_a = SRCA_A;
                o_ctrl.alu_src_b = SRCB_SEXT;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REGDST_RT;
                o_ctrl.mem_to_reg = MEM2REG_MDR;
            end
            ST_MEM_WR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            ST_R_EXEC: begin
                o_ctrl.alu_src_a = SRCA_A;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALUOP_RTYPE;
            end
            ST_R_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REGDST_RD;
                o_ctrl.mem_to_reg = MEM2REG_ALUOUT;
            end
            ST_I_EXEC: begin
                o_ctrl.alu_src_a = SRCA_A;
                o_ctrl.alu_src_b = SRCB_SEXT;
                o_ctrl.alu_op    = i_slt ? ALUOP_SLT : ALUOP_ADD;
            end
            ST_I_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REGDST_RT;
                o_ctrl.mem_to_reg = MEM2REG_ALUOUT;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = SRCA_A;
                o_ctrl.alu_src_b     = SRCB_B;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.branch_ne     = i_bne;
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            ST_JAL: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REGDST_RA;
                o_ctrl.mem_to_reg = MEM2REG_PC;
            end
            ST_JR: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_A;
            end
            default: o_ctrl = CTRL_ZERO;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer. Walks each instruction through
// fetch/decode/execute/memory/writeback, stalls on mem_ready_i, keeps a
// sticky illegal-opcode flag and counts retired instructions.
// Ports:
//   clk_i, rst_i (async, active-low), start_i (leave IDLE)
//   opcode_i/funct_i  IR fields, valid from DECODE onward
//   mem_ready_i       shared memory completed current access
//   *_o controls      Moore decode of the state register (PC/IR load in
//                     FETCH is qualified by mem_ready_i)
//   state_o           debug state, illegal_o sticky flag, instr_cnt_o count
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             branch_ne_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic [1:0]       pc_source_o,
    output logic [3:0]       state_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;
    // Opcode-derived flags latched when leaving DECODE so later states
    // decode purely from registers.
    logic             r_is_lw;
    logic             r_is_slt;
    logic             r_is_bne;
    state_t           w_dispatch;
    logic             w_retire;
    ctrl_t            w_ctrl;

    assign w_dispatch = dispatch(opcode_i, funct_i);

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     w_next = start_i ? ST_FETCH : ST_IDLE;
            ST_FETCH:    w_next = mem_ready_i ? ST_DECODE : ST_FETCH;
            ST_DECODE:   w_next = w_dispatch;
            ST_MEM_ADDR: w_next = r_is_lw ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   w_next = mem_ready_i ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   w_next = mem_ready_i ? ST_FETCH : ST_MEM_WR;
            ST_R_EXEC:   w_next = ST_R_WB;
            ST_I_EXEC:   w_next = ST_I_WB;
            ST_MEM_WB,
            ST_R_WB,
            ST_I_WB,
            ST_BRANCH,
            ST_JUMP,
            ST_JAL,
            ST_JR:       w_next = ST_FETCH;
            default:     w_next = ST_IDLE;
        endcase
    end

    // An instruction retires on every entry into FETCH except from IDLE
    // (the FETCH self-loop while stalled is not an entry).
    assign w_retire = (r_state != ST_IDLE) && (r_state != ST_FETCH) && (w_next == ST_FETCH);

    // State register, instruction flags, sticky illegal and retire counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_illegal <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_is_lw   <= 1'b0;
            r_is_slt  <= 1'b0;
            r_is_bne  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_is_lw  <= (opcode_i == OP_LW);
                r_is_slt <= (opcode_i == OP_SLTI);
                r_is_bne <= opcode_i[0];
                if (w_dispatch == ST_FETCH) begin
                    r_illegal <= 1'b1;
                end else begin
                    r_illegal <= r_illegal;
                end
            end else begin
                r_is_lw   <= r_is_lw;
                r_is_slt  <= r_is_slt;
                r_is_bne  <= r_is_bne;
                r_illegal <= r_illegal;
            end
            if (w_retire) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready_i),
        .i_slt       (r_is_slt),
        .i_bne       (r_is_bne),
        .o_ctrl      (w_ctrl)
    );

    assign pc_write_o      = w_ctrl.pc_write;
    assign pc_write_cond_o = w_ctrl.pc_write_cond;
    assign branch_ne_o     = w_ctrl.branch_ne;
    assign iord_o          = w_ctrl.iord;
    assign mem_read_o      = w_ctrl.mem_read;
    assign mem_write_o     = w_ctrl.mem_write;
    assign ir_write_o      = w_ctrl.ir_write;
    assign reg_write_o     = w_ctrl.reg_write;
    assign reg_dst_o       = w_ctrl.reg_dst;
    assign mem_to_reg_o    = w_ctrl.mem_to_reg;
    assign alu_src_a_o     = w_ctrl.alu_src_a;
    assign alu_src_b_o     = w_ctrl.alu_src_b;
    assign alu_op_o        = w_ctrl.alu_op;
    assign pc_source_o     = w_ctrl.pc_source;
    assign state_o         = r_state;
    assign illegal_o       = r_illegal;
    assign instr_cnt_o     = r_cnt;

endmodule
